// File: rtl/tiny_dnn_pkg.sv
// Shared types and constants for the dst_buf side of the tiny DNN core.
package tiny_dnn_pkg;

    localparam int DST_AW = 11;
    localparam int DST_DW = 32;
    localparam int DST_LW = 12;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } dst_state_t;

    // A zero length request means a full bank.
    function automatic logic [DST_LW-1:0] dst_len(input logic [DST_LW-1:0] l);
        return (l == '0) ? DST_LW'(1 << DST_AW) : l;
    endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry skid FIFO carrying a tlast tag per entry.
module stream_skid2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         last,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic [1:0]   tag;
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_pop;

    assign valid  = (count != 2'd0);
    assign do_pop = pop & valid;
    assign data   = mem[rd_ptr];
    assign last   = tag[rd_ptr] & valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            tag    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                tag[wr_ptr] <= push_last;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            unique case ({push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dst_stream_out.sv
// Drains one dst_buf bank onto a 64-bit AXI-Stream master.
module dst_stream_out
    import tiny_dnn_pkg::*;
#(
    parameter int AW = DST_AW,
    parameter int DW = DST_DW,
    parameter int LW = DST_LW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            bank,
    input  logic [AW-1:0]   base,
    input  logic [LW-1:0]   len,
    input  logic            run,
    output logic            busy,
    output logic            done,
    output logic            dst_v,
    output logic [12:0]     dst_a,
    input  logic [DW-1:0]   dst_d0,
    input  logic [DW-1:0]   dst_d1,
    output logic [2*DW-1:0] m_tdata,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic            m_tlast
);

    dst_state_t    state;
    dst_state_t    state_nx;
    logic          bank_q;
    logic [AW-1:0] base_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] issue_cnt;
    logic [AW-1:0] addr;
    logic          inflight;
    logic          inflight_last;
    logic [1:0]    fifo_count;
    logic [2:0]    occ;
    logic          pop;
    logic          issue;
    logic          issue_last;
    logic          beat_last;

    assign pop        = m_tvalid & m_tready;
    assign beat_last  = pop & m_tlast;
    assign issue_last = (issue_cnt == len_q - LW'(1));
    assign addr       = base_q + issue_cnt[AW-1:0];

    // Occupancy after this edge; the next read lands one cycle later.
    assign occ = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = READ;
            READ:    if (issue && issue_last) state_nx = DRAIN;
            DRAIN:   if (beat_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        issue = 1'b0;
        dst_v = 1'b0;
        dst_a = '0;
        unique case (state)
            READ: begin
                busy  = 1'b1;
                issue = ~run & (occ < 3'd2);
                dst_v = issue;
                dst_a = {bank_q, 1'b0, addr};
            end
            DRAIN: begin
                busy  = 1'b1;
                dst_a = {bank_q, 1'b0, addr};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q        <= 1'b0;
            base_q        <= '0;
            len_q         <= '0;
            issue_cnt     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                bank_q    <= bank;
                base_q    <= base;
                len_q     <= dst_len(len);
                issue_cnt <= '0;
            end else if (issue) begin
                issue_cnt <= issue_cnt + LW'(1);
            end
            inflight      <= issue;
            inflight_last <= issue & issue_last;
            done          <= (state == DRAIN) & beat_last;
        end
    end

    stream_skid2 #(
        .W(2*DW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data ({dst_d1, dst_d0}),
        .push_last (inflight_last),
        .pop       (m_tready),
        .valid     (m_tvalid),
        .data      (m_tdata),
        .last      (m_tlast),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_dst_stream_out.sv
// Scoreboard bench for dst_stream_out with a behavioural dst_buf.
module tb_dst_stream_out;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        bank = 1'b0;
    logic [10:0] base = '0;
    logic [11:0] len = '0;
    logic        run = 1'b0;
    logic        busy;
    logic        done;
    logic        dst_v;
    logic [12:0] dst_a;
    logic [31:0] dst_d0;
    logic [31:0] dst_d1;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [11:0] rd_addr = '0;

    int errors = 0;
    int checks = 0;

    beat_t       exp_q[$];
    logic [12:0] addr_q[$];

    always #5 clk = ~clk;

    dst_stream_out dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bank     (bank),
        .base     (base),
        .len      (len),
        .run      (run),
        .busy     (busy),
        .done     (done),
        .dst_v    (dst_v),
        .dst_a    (dst_a),
        .dst_d0   (dst_d0),
        .dst_d1   (dst_d1),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast)
    );

    function automatic logic [31:0] mval(input logic lane, input logic [12:0] a);
        return {7'h68, lane, 11'h0, a};
    endfunction

    // dst_buf: word latched on the strobe, lanes muxed by the live dst_a[12].
    always @(posedge clk)
        if (dst_v) rd_addr <= dst_a[11:0];
    assign dst_d0 = mval(1'b0, {dst_a[12], rd_addr});
    assign dst_d1 = mval(1'b1, {dst_a[12], rd_addr});

    task automatic do_xfer(
        input  logic        b,
        input  logic [10:0] bs,
        input  logic [11:0] l,
        input  int          mode,
        input  int          run_at,
        input  int          run_len,
        output int          nbeats,
        output int          first_valid,
        output int          beat_span,
        output int          issue_span,
        output int          done_lat
    );
        int n, cyc, budget, run_left;
        int first_beat, last_beat, first_iss, last_iss;
        bit fin, run_used, stall;
        logic [63:0] held_d;
        logic held_l;
        beat_t e;
        logic [12:0] ea;
        logic [10:0] w;
        n = (l == 12'd0) ? 2048 : int'(l);
        for (int i = 0; i < n; i++) begin
            w = bs + 11'(i);
            ea = {b, 1'b0, w};
            addr_q.push_back(ea);
            e.data = {mval(1'b1, ea), mval(1'b0, ea)};
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b1; bank = b; base = bs; len = l;
        run = 1'b0; m_tready = 1'b1;
        nbeats = 0; first_valid = -1; done_lat = -1;
        first_beat = -1; last_beat = -1; first_iss = -1; last_iss = -1;
        fin = 0; run_used = 0; run_left = 0; stall = 0;
        held_d = '0; held_l = 1'b0; cyc = 0;
        budget = 4 * n + 40;
        while (!fin && cyc < budget) begin
            @(negedge clk);
            start = (cyc == 1);
            bank = ~b; base = ~bs; len = 12'd3;
            m_tready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (!run_used && run_len > 0 && nbeats >= run_at) begin
                run_used = 1;
                run_left = run_len;
            end
            run = (run_left > 0);
            if (run_left > 0) run_left--;
            #1;
            if (stall) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== held_d || m_tlast !== held_l) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             cyc, m_tvalid, m_tdata, m_tlast, held_d, held_l);
                end
            end
            if (first_valid < 0 && m_tvalid === 1'b1) first_valid = cyc;
            if (dst_v === 1'b1) begin
                checks++;
                if (run === 1'b1) begin
                    errors++;
                    $display("FAIL issue_during_run cyc=%0d got dst_v=1 want 0", cyc);
                end
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_read cyc=%0d got dst_a=%h want no read", cyc, dst_a);
                end else begin
                    ea = addr_q.pop_front();
                    if (dst_a !== ea) begin
                        errors++;
                        $display("FAIL dst_a cyc=%0d got %h want %h", cyc, dst_a, ea);
                    end
                end
                if (first_iss < 0) first_iss = cyc;
                last_iss = cyc;
            end
            if (dut.u_skid.push === 1'b1) begin
                checks++;
                if (dut.u_skid.count == 2'd2 && !(m_tvalid && m_tready)) begin
                    errors++;
                    $display("FAIL fifo_overflow cyc=%0d got push into count=2 want no push", cyc);
                end
            end
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat cyc=%0d got %h want none", cyc, m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (m_tdata !== e.data || m_tlast !== e.last) begin
                        errors++;
                        $display("FAIL beat cyc=%0d got d=%h l=%b want d=%h l=%b",
                                 cyc, m_tdata, m_tlast, e.data, e.last);
                    end
                end
                nbeats++;
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
            end
            if (done === 1'b1) begin
                fin = 1;
                done_lat = cyc - last_beat;
            end
            stall = (m_tvalid === 1'b1) && (m_tready !== 1'b1);
            held_d = m_tdata;
            held_l = m_tlast;
            cyc++;
        end
        start = 1'b0;
        run = 1'b0;
        m_tready = 1'b1;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL timeout got no done after %0d cycles want done", cyc);
        end
        checks++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got beats=%0d reads=%0d pending want 0",
                     exp_q.size(), addr_q.size());
        end
        exp_q.delete();
        addr_q.delete();
        beat_span = last_beat - first_beat;
        issue_span = last_iss - first_iss;
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, dst_v, m_tvalid, m_tlast} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {busy, done, dst_v, m_tvalid, m_tlast});
        end
        checks++;
        if (dst_a !== 13'h0) begin
            errors++;
            $display("FAIL reset_dst_a got %h want 0000", dst_a);
        end
        checks++;
        if (m_tdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_tdata got %h want 0", m_tdata);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0 || dst_v !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b v=%b dst_v=%b want 0 0 0",
                     busy, m_tvalid, dst_v);
        end
    endtask

    task automatic test_single;
        int nb, fv, bsp, isp, dl;
        do_xfer(1'b0, 11'd5, 12'd1, 0, 0, 0, nb, fv, bsp, isp, dl);
        checks++;
        if (nb != 1) begin errors++; $display("FAIL single_beats got %0d want 1", nb); end
        checks++;
        if (fv != 2) begin errors++; $display("FAIL single_latency got %0d want 2", fv); end
        checks++;
        if (dl != 1) begin errors++; $display("FAIL single_done got %0d want 1", dl); end
    endtask

    task automatic test_full_rate;
        int nb, fv, bsp, isp, dl;
        do_xfer(1'b1, 11'd0, 12'd16, 0, 0, 0, nb, fv, bsp, isp, dl);
        checks++;
        if (nb != 16) begin errors++; $display("FAIL burst_beats got %0d want 16", nb); end
        checks++;
        if (bsp != 15) begin errors++; $display("FAIL burst_beat_span got %0d want 15", bsp); end
        checks++;
        if (isp != 15) begin errors++; $display("FAIL burst_issue_span got %0d want 15", isp); end
        checks++;
        if (fv != 2) begin errors++; $display("FAIL burst_latency got %0d want 2", fv); end
        checks++;
        if (dl != 1) begin errors++; $display("FAIL burst_done got %0d want 1", dl); end
    endtask

    task automatic test_backpressure;
        int nb, fv, bsp, isp, dl;
        do_xfer(1'b0, 11'd100, 12'd8, 1, 0, 0, nb, fv, bsp, isp, dl);
        checks++;
        if (nb != 8) begin errors++; $display("FAIL bp_beats got %0d want 8", nb); end
        checks++;
        if (dl != 1) begin errors++; $display("FAIL bp_done got %0d want 1", dl); end
    endtask

    task automatic test_wrap_len0;
        int nb, fv, bsp, isp, dl;
        do_xfer(1'b1, 11'd2047, 12'd2, 0, 0, 0, nb, fv, bsp, isp, dl);
        checks++;
        if (nb != 2) begin errors++; $display("FAIL wrap_beats got %0d want 2", nb); end
        do_xfer(1'b0, 11'd300, 12'd0, 0, 0, 0, nb, fv, bsp, isp, dl);
        checks++;
        if (nb != 2048) begin errors++; $display("FAIL len0_beats got %0d want 2048", nb); end
        checks++;
        if (bsp != 2047) begin errors++; $display("FAIL len0_span got %0d want 2047", bsp); end
    endtask

    task automatic test_run_stall;
        int nb, fv, bsp, isp, dl;
        do_xfer(1'b1, 11'd40, 12'd10, 0, 3, 5, nb, fv, bsp, isp, dl);
        checks++;
        if (nb != 10) begin errors++; $display("FAIL run_beats got %0d want 10", nb); end
        checks++;
        if (isp != 14) begin errors++; $display("FAIL run_issue_span got %0d want 14", isp); end
    endtask

    task automatic test_reset_mid;
        int nb, fv, bsp, isp, dl, cyc;
        @(negedge clk);
        start = 1'b1; bank = 1'b1; base = 11'd64; len = 12'd10; m_tready = 1'b1;
        nb = 0;
        cyc = 0;
        while (nb < 4 && cyc < 50) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (m_tvalid === 1'b1 && m_tready === 1'b1) nb++;
            cyc++;
        end
        checks++;
        if (nb != 4) begin errors++; $display("FAIL abort_reach got %0d beats want 4", nb); end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, dst_v, m_tvalid, m_tlast} !== 5'b0 || dst_a !== 13'h0 || m_tdata !== 64'h0) begin
            errors++;
            $display("FAIL abort_outputs got ctl=%b a=%h d=%h want 0 0 0",
                     {busy, done, dst_v, m_tvalid, m_tlast}, dst_a, m_tdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done got done=%b busy=%b want 0 0", done, busy);
        end
        reset = 1'b0;
        do_xfer(1'b0, 11'd7, 12'd5, 0, 0, 0, nb, fv, bsp, isp, dl);
        checks++;
        if (nb != 5) begin errors++; $display("FAIL after_abort_beats got %0d want 5", nb); end
        checks++;
        if (dl != 1) begin errors++; $display("FAIL after_abort_done got %0d want 1", dl); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_rate();
        test_backpressure();
        test_wrap_len0();
        test_run_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
